uart_tx_arbiter: RTL and testbench



---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/rr_pick.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 577 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and arbiter state type.
package uart_pkg;
  localparam int SYS_PERIOD = 50_000_000;
  localparam int BPS = 115_200;
  localparam int HALF_BIT_PERIOD =
    SYS_PERIOD / BPS / 2;
  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE
  } arb_state_t;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus transmitter start/data/done.
// master: requesters + transmitter; slave: the arbiter.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = UART_DATA_W
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_done;

  modport master (
    output req_valid, req_data, req_last,
    output tx_done,
    input  req_ready, tx_start, tx_data
  );

  modport slave (
    input  req_valid, req_data, req_last,
    input  tx_done,
    output req_ready, tx_start, tx_data
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit after ptr.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any_valid
);
  logic [IW-1:0] cand;

  // Scan farthest first so the nearest hit wins.
  always_comb begin
    idx       = ptr;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        idx       = cand;
        any_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin per-packet arbiter in front of one UART TX.
// UART_ARB_TIMEOUT_EN: revoke a stalled grant, pulse timeout_evt.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_W      = UART_DATA_W,
  parameter  int MAX_BURST   = 16,
  parameter  int TIMEOUT_CYC = 4340,
  localparam int IW          = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.slave  bus,
  output logic [IW-1:0]     grant_id,
  output logic              grant_active
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic              timeout_evt
`endif
);
  if (NUM_REQ < 2 || NUM_REQ > 8 ||
      MAX_BURST < 1 || MAX_BURST > 255 ||
      TIMEOUT_CYC < 1) begin : g_param_chk
    $error("uart_tx_arbiter: bad parameter");
  end

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     gid_d;
  logic              gact_d;
  logic [7:0]        burst_q, burst_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              start_q, start_d;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic              hs;

  logic [DATA_W-1:0] req_byte [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_byte[g] =
      bus.req_data[g*DATA_W +: DATA_W];
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] stall_q, stall_d;
  logic          evt_d;
`endif

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  assign bus.tx_start = start_q;
  assign bus.tx_data  = data_q;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gid_d         = grant_id;
    gact_d        = grant_active;
    burst_d       = burst_q;
    last_d        = last_q;
    data_d        = data_q;
    start_d       = 1'b0;
    hs            = 1'b0;
    bus.req_ready = '0;
`ifdef UART_ARB_TIMEOUT_EN
    stall_d       = stall_q;
    evt_d         = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gid_d   = pick_idx;
          gact_d  = 1'b1;
          burst_d = '0;
          state_d = SEND;
`ifdef UART_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
        end
      end
      SEND: begin
        hs = bus.req_valid[grant_id];
        bus.req_ready[grant_id] = hs;
        if (hs) begin
          data_d  = req_byte[grant_id];
          start_d = 1'b1;
          burst_d = burst_q + 8'd1;
          last_d  = bus.req_last[grant_id];
          state_d = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
          stall_d = '0;
        end else if (stall_q ==
                     TW'(TIMEOUT_CYC - 1)) begin
          evt_d   = 1'b1;
          stall_d = '0;
          ptr_d   = grant_id;
          gact_d  = 1'b0;
          state_d = IDLE;
        end else begin
          stall_d = stall_q + 1'b1;
`endif
        end
      end
      WAIT_DONE: begin
        if (bus.tx_done) begin
          // Packet end or burst cap both rotate.
          if (last_q ||
              burst_q == 8'(MAX_BURST)) begin
            ptr_d   = grant_id;
            gact_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= IW'(NUM_REQ - 1);
      grant_id     <= '0;
      grant_active <= 1'b0;
      burst_q      <= '0;
      last_q       <= 1'b0;
      data_q       <= '0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_id     <= gid_d;
      grant_active <= gact_d;
      burst_q      <= burst_d;
      last_q       <= last_d;
      data_q       <= data_d;
      start_q      <= start_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q     <= '0;
      timeout_evt <= 1'b0;
    end else begin
      stall_q     <= stall_d;
      timeout_evt <= evt_d;
    end
  end
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requesters, TX model,
// packet-level round-robin reference.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NR = 4;
  localparam int DW = UART_DATA_W;
  localparam int MB = 16;
  localparam int TO = 50;
  localparam int QD = 256;

  logic clk;
  logic rst_n;
  logic [1:0] grant_id;
  logic grant_active;
`ifdef UART_ARB_TIMEOUT_EN
  logic timeout_evt;
`endif

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ     (NR),
    .DATA_W      (DW),
    .MAX_BURST   (MB),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .grant_id     (grant_id),
`ifdef UART_ARB_TIMEOUT_EN
    .grant_active (grant_active),
    .timeout_evt  (timeout_evt)
`else
    .grant_active (grant_active)
`endif
  );

  int checks;
  int errors;

  logic [8:0] mem [NR][QD];
  int head [NR];
  int tail [NR];
  logic [NR-1:0] stall;
  logic [NR-1:0] hs;
  logic [8:0] drv_e;
  logic [9:0] log_q [$];
  logic [9:0] exp_q [$];
  int m_ptr;
  int frame_lo;
  int frame_hi;
  bit pend;
  int cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Requesters: present queue heads, pop on handshake.
  initial begin
    hs = '0;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++)
        if (hs[i] && rst_n && head[i] < tail[i])
          head[i]++;
      for (int i = 0; i < NR; i++) begin
        drv_e = mem[i][head[i] % QD];
        bus.req_valid[i] = rst_n && !stall[i] &&
                           (head[i] < tail[i]);
        bus.req_data[i*DW +: DW] = drv_e[7:0];
        bus.req_last[i] = drv_e[8];
      end
      #1;
      hs = bus.req_valid & bus.req_ready;
    end
  end

  // Transmitter model: log bytes, answer with tx_done.
  initial begin
    bus.tx_done = 1'b0;
    pend = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (bus.tx_start || (|hs)) begin
          checks++;
          if (bus.tx_start !== (|hs)) begin
            errors++;
            $display("FAIL tx_start_latency: tx_start=%b prev_handshake=%b",
                     bus.tx_start, |hs);
          end
        end
        if (bus.tx_start) begin
          checks++;
          if (pend) begin
            errors++;
            $display("FAIL tx_start_overlap: got start while busy, expected none");
          end
          log_q.push_back({grant_id, bus.tx_data});
          pend = 1'b1;
          cnt = $urandom_range(frame_hi, frame_lo);
        end else if (pend) begin
          cnt--;
          if (cnt == 0) begin
            bus.tx_done = 1'b1;
            pend = 1'b0;
          end
        end
      end
    end
  end

  task automatic push_pkt(input int r, input int len,
                          input bit closed);
    for (int b = 0; b < len; b++) begin
      logic [7:0] d;
      d = 8'($urandom);
      mem[r][tail[r] % QD] = {closed && (b == len - 1), d};
      tail[r]++;
    end
  endtask

  // Whole-packet round robin over the pending queues.
  task automatic run_model();
    int hp [NR];
    int sel;
    int n;
    bit found;
    logic [8:0] e;
    for (int i = 0; i < NR; i++) hp[i] = head[i];
    for (int guard = 0; guard < 1000; guard++) begin
      found = 1'b0;
      sel = 0;
      for (int k = 1; k <= NR; k++) begin
        if (!found && hp[(m_ptr + k) % NR] <
                      tail[(m_ptr + k) % NR]) begin
          sel = (m_ptr + k) % NR;
          found = 1'b1;
        end
      end
      if (!found) break;
      n = 0;
      do begin
        e = mem[sel][hp[sel] % QD];
        hp[sel]++;
        n++;
        exp_q.push_back({2'(sel), e[7:0]});
      end while (!e[8] && n < MB && hp[sel] < tail[sel]);
      m_ptr = sel;
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int c;
    c = 0;
    while ((log_q.size() < exp_q.size() || grant_active)
           && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (c < budget);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    stall = '0;
    log_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    m_ptr = NR - 1;
  endtask

  task automatic compare_log(input string tag);
    checks++;
    if (log_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d bytes, expected %0d",
               tag, log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_byte%0d: got id=%0d data=%h, expected id=%0d data=%h",
                 tag, i, log_q[i][9:8], log_q[i][7:0],
                 exp_q[i][9:8], exp_q[i][7:0]);
      end
    end
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stall = '0;
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    frame_lo = 1;
    frame_hi = 4;
    repeat (3) @(negedge clk);
    #2;
    checks += 5;
    if (bus.req_ready !== '0) begin
      errors++;
      $display("FAIL reset_req_ready: got %b, expected 0", bus.req_ready);
    end
    if (bus.tx_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_tx_start: got %b, expected 0", bus.tx_start);
    end
    if (bus.tx_data !== '0) begin
      errors++;
      $display("FAIL reset_tx_data: got %h, expected 0", bus.tx_data);
    end
    if (grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_grant_id: got %0d, expected 0", grant_id);
    end
    if (grant_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_grant_active: got %b, expected 0", grant_active);
    end
    rst_n = 1'b1;
    m_ptr = NR - 1;
    repeat (4) @(negedge clk);
    #2;
    checks++;
    if (grant_active !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: got grant_active=%b, expected 0", grant_active);
    end
  endtask

  task automatic test_single();
    bit ok;
    frame_lo = 20 * HALF_BIT_PERIOD;
    frame_hi = 20 * HALF_BIT_PERIOD;
    @(negedge clk);
    #3;
    mem[2][tail[2] % QD] = 9'h041;
    tail[2]++;
    mem[2][tail[2] % QD] = 9'h142;
    tail[2]++;
    exp_q.push_back({2'd2, 8'h41});
    exp_q.push_back({2'd2, 8'h42});
    m_ptr = 2;
    @(negedge clk);
    #2;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single_ready_idle: got %b, expected 0000", bus.req_ready);
    end
    @(negedge clk);
    #2;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready_lat: got %b, expected 0100", bus.req_ready);
    end
    while (log_q.size() < 1 && grant_active) @(negedge clk);
    repeat (10) @(negedge clk);
    #2;
    checks++;
    if (bus.req_ready !== 4'b0000 || grant_active !== 1'b1) begin
      errors++;
      $display("FAIL single_wait_done: got ready=%b active=%b, expected 0000/1",
               bus.req_ready, grant_active);
    end
    wait_idle(12000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_timeout: got no idle, expected idle within budget");
    end
    compare_log("single");
    checks += 2;
    if (grant_id !== 2'd2) begin
      errors++;
      $display("FAIL single_grant_id: got %0d, expected 2", grant_id);
    end
    if (grant_active !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got active=%b, expected 0", grant_active);
    end
  endtask

  task automatic test_rr_order();
    bit ok;
    do_reset();
    frame_lo = 1;
    frame_hi = 8;
    @(negedge clk);
    #3;
    push_pkt(0, 1, 1'b1);
    push_pkt(1, 1, 1'b1);
    push_pkt(3, 1, 1'b1);
    run_model();
    wait_idle(500, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rr1_timeout: got no idle, expected idle");
    end
    compare_log("rr1");
    @(negedge clk);
    #3;
    push_pkt(0, 1, 1'b1);
    push_pkt(3, 1, 1'b1);
    run_model();
    wait_idle(500, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rr2_timeout: got no idle, expected idle");
    end
    compare_log("rr2");
  endtask

  task automatic test_burst_cap();
    bit ok;
    frame_lo = 1;
    frame_hi = 5;
    @(negedge clk);
    #3;
    push_pkt(1, 20, 1'b1);
    push_pkt(2, 3, 1'b1);
    run_model();
    wait_idle(2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL burst_timeout: got no idle, expected idle");
    end
    compare_log("burst");
  endtask

  task automatic test_random();
    bit ok;
    int tot;
    frame_lo = 1;
    frame_hi = 6;
    for (int r = 0; r < 5; r++) begin
      @(negedge clk);
      #3;
      tot = 0;
      for (int i = 0; i < NR; i++) begin
        int np;
        np = $urandom_range(2, 0);
        for (int p = 0; p < np; p++) begin
          push_pkt(i, $urandom_range(20, 1), 1'b1);
          tot++;
        end
      end
      if (tot == 0) push_pkt($urandom_range(NR - 1, 0), 3, 1'b1);
      run_model();
      wait_idle(5000, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand%0d_timeout: got no idle, expected idle", r);
      end
      compare_log($sformatf("rand%0d", r));
    end
  endtask

  task automatic test_stall();
    bit ok;
    int c;
    int nlog;
    do_reset();
    frame_lo = 2;
    frame_hi = 6;
    @(negedge clk);
    #3;
    push_pkt(0, 6, 1'b1);
    push_pkt(1, 2, 1'b1);
    run_model();
    c = 0;
    while (log_q.size() < 3 && c < 500) begin
      @(negedge clk);
      c++;
    end
    stall[0] = 1'b1;
    repeat (12) @(negedge clk);
    nlog = log_q.size();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #2;
      checks++;
      if (bus.req_ready !== 4'b0000 || grant_active !== 1'b1 ||
          grant_id !== 2'd0 || log_q.size() != nlog) begin
        errors++;
        $display("FAIL stall_hold%0d: got ready=%b active=%b id=%0d bytes=%0d, expected 0000/1/0/%0d",
                 k, bus.req_ready, grant_active, grant_id,
                 log_q.size(), nlog);
      end
    end
    stall[0] = 1'b0;
    wait_idle(1000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_timeout: got no idle, expected idle");
    end
    compare_log("stall");
  endtask

  task automatic test_reset_mid();
    bit ok;
    int c;
    do_reset();
    frame_lo = 20;
    frame_hi = 30;
    @(negedge clk);
    #3;
    push_pkt(1, 5, 1'b1);
    c = 0;
    while (log_q.size() < 3 && c < 500) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (bus.req_ready !== '0) begin
      errors++;
      $display("FAIL rstmid_req_ready: got %b, expected 0", bus.req_ready);
    end
    if (bus.tx_start !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_tx_start: got %b, expected 0", bus.tx_start);
    end
    if (bus.tx_data !== '0) begin
      errors++;
      $display("FAIL rstmid_tx_data: got %h, expected 0", bus.tx_data);
    end
    if (grant_id !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_grant_id: got %0d, expected 0", grant_id);
    end
    if (grant_active !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_grant_active: got %b, expected 0", grant_active);
    end
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    log_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    m_ptr = NR - 1;
    frame_lo = 1;
    frame_hi = 4;
    @(negedge clk);
    #3;
    push_pkt(3, 1, 1'b1);
    push_pkt(1, 2, 1'b1);
    push_pkt(0, 1, 1'b1);
    run_model();
    wait_idle(500, ok);
    checks += 2;
    if (!ok) begin
      errors++;
      $display("FAIL rstmid_timeout: got no idle, expected idle");
    end
    if (log_q.size() == 0 || log_q[0][9:8] !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_first: got first id=%0d, expected 0",
               log_q.size() ? log_q[0][9:8] : 2'd3);
    end
    compare_log("rstmid");
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int c;
    int t2;
    bit ok;
    do_reset();
    frame_lo = 3;
    frame_hi = 3;
    @(negedge clk);
    #3;
    push_pkt(0, 2, 1'b0);
    push_pkt(1, 1, 1'b1);
    c = 0;
    t2 = -1;
    while (timeout_evt !== 1'b1 && c < 2000) begin
      @(negedge clk);
      c++;
      if (t2 < 0 && log_q.size() >= 2) t2 = c;
    end
    checks += 3;
    if (timeout_evt !== 1'b1) begin
      errors++;
      $display("FAIL timeout_evt: got no pulse, expected pulse");
    end
    if (c - t2 < TO || c - t2 > TO + 10) begin
      errors++;
      $display("FAIL timeout_gap: got %0d cycles, expected %0d..%0d",
               c - t2, TO, TO + 10);
    end
    if (grant_active !== 1'b0) begin
      errors++;
      $display("FAIL timeout_release: got active=%b, expected 0", grant_active);
    end
    @(negedge clk);
    checks++;
    if (timeout_evt !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse_w: got %b, expected 0", timeout_evt);
    end
    exp_q.push_back(10'h0);
    exp_q.push_back(10'h0);
    exp_q.push_back(10'h0);
    wait_idle(500, ok);
    checks += 2;
    if (!ok) begin
      errors++;
      $display("FAIL timeout_next: got no idle, expected idle");
    end
    if (log_q.size() < 3 || log_q[2][9:8] !== 2'd1) begin
      errors++;
      $display("FAIL timeout_next_id: got %0d bytes, expected req 1 third",
               log_q.size());
    end
    log_q.delete();
    exp_q.delete();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_rr_order();
    test_burst_cap();
    test_random();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_stall();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
